// File: rtl/ws2812_tx_if.sv
// Signal bundle between the LED control system and the WS2812 serial transmitter.
interface ws2812_tx_if #(
    parameter int NUM_LEDS = 12
);
    logic [NUM_LEDS*24-1:0] colors;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   led_dout;

    modport master (
        output colors,
        output start,
        input  busy,
        input  done,
        input  led_dout
    );

    modport slave (
        input  colors,
        input  start,
        output busy,
        output done,
        output led_dout
    );
endinterface

// File: rtl/ws2812_tx.sv
// WS2812 single-wire NRZ frame transmitter: snapshots all pixels on a start edge, then sends them.
// Optional WS2812_GRB_ORDER_EN: send each pixel as G,R,B instead of the supplied R,G,B.
module ws2812_tx #(
    parameter int NUM_LEDS = 12,
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int TBIT_CYC = 63,
    parameter int TRST_CYC = 2500
) (
    input  logic           clk_clk,
    input  logic           reset_reset_n,
    ws2812_tx_if.slave     bus
);
    localparam int FRAME_W = NUM_LEDS * 24;
    localparam int CYC_MAX = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int LED_W   = $clog2(NUM_LEDS + 1);

    localparam logic [CYC_W-1:0] TBIT_LAST = CYC_W'(TBIT_CYC - 1);
    localparam logic [CYC_W-1:0] TRST_LAST = CYC_W'(TRST_CYC - 1);
    localparam logic [CYC_W-1:0] T0H_C     = CYC_W'(T0H_CYC);
    localparam logic [CYC_W-1:0] T1H_C     = CYC_W'(T1H_CYC);
    localparam logic [LED_W-1:0] LED_LAST  = LED_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BIT,
        GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [CYC_W-1:0]   cyc_cnt_reg, cyc_cnt_next;
    logic [4:0]         bit_cnt_reg, bit_cnt_next;
    logic [LED_W-1:0]   led_cnt_reg, led_cnt_next;
    logic [FRAME_W-1:0] shadow_reg, shadow_next;
    logic               start_q_reg;
    logic               led_dout_reg, led_dout_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [FRAME_W-1:0] load_word;
    logic [CYC_W-1:0]   thi_next;
    logic               start_rise;

    assign start_rise = bus.start & ~start_q_reg;

    // The shadow holds the whole frame in wire order: the first bit to send sits at the MSB.
    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_pix
            logic [23:0] px;
            assign px = bus.colors[24*gi +: 24];
`ifdef WS2812_GRB_ORDER_EN
            assign load_word[FRAME_W-24*(gi+1) +: 24] = {px[15:8], px[23:16], px[7:0]};
`else
            assign load_word[FRAME_W-24*(gi+1) +: 24] = px;
`endif
        end
    endgenerate

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg    <= IDLE;
            cyc_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            led_cnt_reg  <= '0;
            shadow_reg   <= '0;
            start_q_reg  <= 1'b1;
            led_dout_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cyc_cnt_reg  <= cyc_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            led_cnt_reg  <= led_cnt_next;
            shadow_reg   <= shadow_next;
            start_q_reg  <= bus.start;
            led_dout_reg <= led_dout_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cyc_cnt_next = cyc_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        led_cnt_next = led_cnt_reg;
        shadow_next  = shadow_reg;

        case (state_reg)
            IDLE: begin
                if (start_rise) begin
                    shadow_next  = load_word;
                    cyc_cnt_next = '0;
                    bit_cnt_next = '0;
                    led_cnt_next = '0;
                    state_next   = BIT;
                end
            end
            BIT: begin
                if (cyc_cnt_reg == TBIT_LAST) begin
                    cyc_cnt_next = '0;
                    shadow_next  = {shadow_reg[FRAME_W-2:0], 1'b0};
                    if (bit_cnt_reg == 5'd23) begin
                        bit_cnt_next = '0;
                        led_cnt_next = led_cnt_reg + LED_W'(1);
                        if (led_cnt_reg == LED_LAST) begin
                            state_next = GAP;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
                end
            end
            GAP: begin
                if (cyc_cnt_reg == TRST_LAST) begin
                    cyc_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered from the upcoming state so they line up with the counters.
        thi_next      = shadow_next[FRAME_W-1] ? T1H_C : T0H_C;
        led_dout_next = (state_next == BIT) && (cyc_cnt_next < thi_next);
        busy_next     = (state_next != IDLE);
        done_next     = (state_next == GAP) && (cyc_cnt_next == TRST_LAST);
    end

    assign bus.led_dout = led_dout_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
endmodule

// File: tb/tb_ws2812_tx.sv
// Randomized bench for ws2812_tx: a scoreboard of expected pixel words checked by a line decoder.
module tb_ws2812_tx;
    localparam int NUM_LEDS  = 2;
    localparam int T0H       = 2;
    localparam int T1H       = 4;
    localparam int TBIT      = 6;
    localparam int TRST      = 10;
    localparam int FRAME_CYC = NUM_LEDS * 24 * TBIT + TRST;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ws2812_tx_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    ws2812_tx #(
        .NUM_LEDS(NUM_LEDS),
        .T0H_CYC (T0H),
        .T1H_CYC (T1H),
        .TBIT_CYC(TBIT),
        .TRST_CYC(TRST)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .bus          (bus)
    );

    int errors = 0;
    int checks = 0;
    int frames = 0;
    int frames_exp = 0;
    logic [23:0] exp_q[$];

    // Reference: the 24 bits of a pixel in the order they appear on the wire, first bit at MSB.
    function automatic logic [23:0] wire_order(input logic [23:0] px);
        logic [7:0] r, g, b;
        r = px[23:16];
        g = px[15:8];
        b = px[7:0];
`ifdef WS2812_GRB_ORDER_EN
        return {g, r, b};
`else
        return {r, g, b};
`endif
    endfunction

    function automatic logic [NUM_LEDS*24-1:0] rand_colors();
        logic [NUM_LEDS*24-1:0] c;
        for (int i = 0; i < NUM_LEDS; i++) c[24*i +: 24] = 24'($urandom);
        return c;
    endfunction

    // Monitor: decodes the line, checks widths/period, busy length and the done pulse.
    initial begin : monitor
        int cyc, hi, bitn, run, done_cnt, last_rise;
        logic [23:0] word, exp_w;
        logic prev_led, prev_busy;
        cyc = 0; hi = 0; bitn = 0; run = 0; done_cnt = 0; last_rise = -1;
        word = '0; prev_led = 1'b0; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                checks++;
                if (bus.busy || bus.done || bus.led_dout) begin
                    errors++;
                    $display("FAIL reset_outputs: busy=%0b done=%0b led=%0b required all 0",
                             bus.busy, bus.done, bus.led_dout);
                end
                hi = 0; bitn = 0; run = 0; done_cnt = 0; last_rise = -1;
                prev_led = 1'b0; prev_busy = 1'b0;
            end else begin
                if (bus.led_dout && !prev_led) begin
                    if (last_rise >= 0) begin
                        checks++;
                        if (cyc - last_rise != TBIT) begin
                            errors++;
                            $display("FAIL bit_period: got %0d required %0d", cyc - last_rise, TBIT);
                        end
                    end
                    last_rise = cyc;
                end
                if (bus.led_dout) hi++;
                if (prev_led && !bus.led_dout) begin
                    checks++;
                    if (hi != T0H && hi != T1H) begin
                        errors++;
                        $display("FAIL high_width: got %0d required %0d or %0d", hi, T0H, T1H);
                    end
                    word = {word[22:0], (hi == T1H)};
                    bitn++;
                    hi = 0;
                    if (bitn == 24) begin
                        bitn = 0;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL pixel_unexpected: got %06h required none", word);
                        end else begin
                            exp_w = exp_q.pop_front();
                            $display("pixel: got %06h expected %06h", word, exp_w);
                            if (word !== exp_w) begin
                                errors++;
                                $display("FAIL pixel_data: got %06h required %06h", word, exp_w);
                            end
                        end
                    end
                end
                if (bus.busy) begin
                    run++;
                    if (bus.done) begin
                        done_cnt++;
                        checks++;
                        if (run != FRAME_CYC) begin
                            errors++;
                            $display("FAIL done_position: got cycle %0d required %0d", run, FRAME_CYC);
                        end
                    end
                end else begin
                    checks++;
                    if (bus.done || bus.led_dout) begin
                        errors++;
                        $display("FAIL idle_outputs: done=%0b led=%0b required 0 0", bus.done, bus.led_dout);
                    end
                    if (prev_busy) begin
                        frames++;
                        checks++;
                        if (run != FRAME_CYC) begin
                            errors++;
                            $display("FAIL busy_length: got %0d required %0d", run, FRAME_CYC);
                        end
                        checks++;
                        if (done_cnt != 1 || bitn != 0) begin
                            errors++;
                            $display("FAIL frame_end: done pulses %0d partial bits %0d required 1 and 0",
                                     done_cnt, bitn);
                        end
                        $display("frame %0d: busy %0d cycles, done pulses %0d", frames, run, done_cnt);
                        run = 0; done_cnt = 0; last_rise = -1;
                    end
                end
                prev_led = bus.led_dout;
                prev_busy = bus.busy;
            end
        end
    end

    task automatic issue_start(input logic [NUM_LEDS*24-1:0] c);
        bus.start = 1'b0;
        bus.colors = c;
        @(posedge clk); #1;
        bus.start = 1'b1;
        for (int i = 0; i < NUM_LEDS; i++) exp_q.push_back(wire_order(c[24*i +: 24]));
        frames_exp++;
        @(posedge clk); #1;
        checks++;
        if (!(bus.busy && bus.led_dout)) begin
            errors++;
            $display("FAIL start_latency: busy=%0b led=%0b required 1 1", bus.busy, bus.led_dout);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < FRAME_CYC + 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL frame_timeout: busy still %0b after %0d cycles required 0", bus.busy, n);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frames(input string tag);
        checks++;
        if (frames != frames_exp || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_count_%s: got %0d frames (%0d pending) required %0d (0 pending)",
                     tag, frames, exp_q.size(), frames_exp);
        end
    endtask

    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [NUM_LEDS*24-1:0] c;
        bus.start = 1'b0;
        bus.colors = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;

        // Directed pixel pair.
        c = '0;
        c[23:0]  = 24'hFF0000;
        c[47:24] = 24'h0000A5;
        issue_start(c);
        wait_idle();
        check_frames("directed");

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            issue_start(rand_colors());
            wait_idle();
        end
        check_frames("random");

        // Retrigger and colour change mid-frame must not affect the running frame.
        issue_start(rand_colors());
        repeat (100) @(posedge clk);
        #1;
        bus.colors = rand_colors();
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        wait_idle();
        repeat (30) @(posedge clk);
        #1;
        check_frames("retrigger");

        // Start held high through reset release: nothing may be sent.
        bus.start = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check_frames("held_start");
        issue_start(rand_colors());
        wait_idle();
        check_frames("after_held");

        // Reset at bit 10 of pixel 0 aborts the frame with no done.
        issue_start(rand_colors());
        repeat (10 * TBIT) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy || bus.led_dout) begin
            errors++;
            $display("FAIL reset_abort: busy=%0b led=%0b required 0 0", bus.busy, bus.led_dout);
        end
        exp_q.delete();
        frames_exp--;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_frames("abort");
        issue_start(rand_colors());
        wait_idle();
        check_frames("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Serial LED-strip transmitter that consumes the per-pixel 24-bit colour words and the start strobe produced by the LED control system and drives a WS2812-class single-wire data line. On a rising edge of start it snapshots all pixel colours and shifts one frame out with NRZ pulse-width encoding. It then holds the line low for the latch gap. It sits between the processor-side PIO colour registers and the strip's DIN pin.

## Interface
Parameters:
- NUM_LEDS, 12, pixels per frame
- T0H_CYC, 20, high time of a 0 bit in clocks (0.4 us at 50 MHz)
- T1H_CYC, 40, high time of a 1 bit in clocks (0.8 us)
- TBIT_CYC, 63, total bit period in clocks (1.25 us)
- TRST_CYC, 2500, low latch gap after the frame in clocks (50 us)

Ports (single clock; reset is asynchronous, active-low):
- clk_clk  input  1  system clock
- reset_reset_n  input  1  asynchronous active-low reset
- colors  input  NUM_LEDS*24  pixel i at [24*i+23:24*i], {R[7:0],G[7:0],B[7:0]}; pixel 0 is sent first
- start  input  1  level from PIO; a 0->1 transition requests a frame
- busy  output  1  high from frame accept until the latch gap ends
- done  output  1  one-cycle pulse at the end of the latch gap
- led_dout  output  1  serial data to the strip

## Operation
- States: IDLE, BIT, GAP.
- start_q registers start. A rising edge is start=1 with start_q=0.
- IDLE: when a rising edge is seen, the block loads the shadow register from colors, clears led_cnt, bit_cnt and cyc_cnt, and goes to BIT. busy=1 and led_dout=1 take effect at that same edge.
- BIT: led_dout=1 while cyc_cnt < THI, otherwise 0. THI = T1H_CYC when the current bit is 1, else T0H_CYC.
- BIT, bit end: when cyc_cnt = TBIT_CYC-1, cyc_cnt returns to 0 and the block advances to the next bit, MSB first (bit_cnt 0..23).
- BIT, pixel end: after bit 23, led_cnt increments.
- BIT, frame end: after bit 23 of pixel NUM_LEDS-1, the block goes to GAP.
- GAP: led_dout=0 for TRST_CYC clocks. On the last GAP cycle, done=1. The block then returns to IDLE with busy=0.
- Rising edges of start during BIT or GAP are ignored and not queued. A start held high produces exactly one frame.
- colors may change freely while busy; only the snapshot is transmitted.
- Counter widths: cyc_cnt is clog2(max(TBIT_CYC,TRST_CYC)). bit_cnt is 5 bits. led_cnt is clog2(NUM_LEDS+1).
- Constraints: T0H_CYC < T1H_CYC < TBIT_CYC. NUM_LEDS >= 1.
- Reset values: state=IDLE, led_dout=0, busy=0, done=0, all counters 0, shadow 0.
- start_q resets to 1. This prevents a start held high through reset from firing.
- Reset asserted mid-frame aborts immediately with the line low. No done is issued.

## Timing
- Start rising edge sampled at clock edge k: led_dout rises at edge k, and busy rises at edge k.
- Each bit occupies exactly TBIT_CYC clocks. There are no inter-bit or inter-pixel gaps.
- Frame length: busy is high for NUM_LEDS*24*TBIT_CYC + TRST_CYC clocks.
- done is asserted in the final busy cycle. busy=0 and state=IDLE take effect on the following edge.
- The earliest accepted new start edge is the cycle after busy falls. start must have been seen low at some point before that cycle.

## Configuration
- WS2812_GRB_ORDER_EN
  - Defined: each pixel is transmitted G[7:0], R[7:0], B[7:0], MSB first. This is the native WS2812/WS2812B order.
  - Undefined: the 24-bit word is transmitted as supplied ({R,G,B}, MSB first), for RGB-order strips.
- The reordering happens at snapshot load. Timing is identical in both builds.

## Test plan
Use bench parameters NUM_LEDS=2, T0H_CYC=2, T1H_CYC=4, TBIT_CYC=6, TRST_CYC=10.
- Reset then idle: led_dout=0, busy=0, done=0 for 50 clocks with start=0.
- start 0->1 with pixel0=24'hFF0000, pixel1=24'h0000A5, macro defined:
  - decoded bit stream is 00 FF 00 00 00 A5, with each 1 bit high 4 cycles and each 0 bit high 2 cycles;
  - busy high 298 cycles;
  - one done pulse on cycle 298.
- Same stimulus with macro undefined: decoded stream is FF 00 00 00 00 A5.
- Pulse start again at cycle 100 and change colors mid-frame: no second frame. The transmitted data matches the values present at the accepting edge.
- Hold start=1 through reset deassertion and the frame end: zero frames after reset. After start is dropped and re-raised, exactly one frame is sent.
- Assert reset_reset_n=0 at bit 10 of pixel 0: led_dout=0 and busy=0 immediately, no done pulse. A new start edge after release sends a full 298-cycle frame.
